return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Hardware return-address stack that services the push/pop requests issued by the pipeline controller for JSB (call) and RET.
- On push it stores the return PC. It always presents the current top entry combinationally, so the fetch PC mux can select it in the same cycle pop is asserted.
- Sits beside the PC logic in fetch/decode and reports occupancy and sticky error flags for debug.

Parameters:
- AW, 12, width of a stored return address in bits.
- DEPTH, 8, number of stack entries; must be at least 2, need not be a power of 2.
- CW, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  store push_addr as the new top this cycle.
- pop  input  1  discard the top entry this cycle.
- push_addr  input  AW  return address to store (PC of the instruction after JSB).
- clear  input  1  synchronous flush: empties the stack and clears the error flags.
- top_addr  output  AW  current top entry, combinational from registered state.
- top_valid  output  1  high when count>0.
- count  output  CW  number of valid entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Values during/after reset: count=0, write pointer sp=0, all entries=0, overflow=0, underflow=0, top_addr=0, top_valid=0, empty=1, full=0.
- Reset asserted mid-operation aborts any in-flight push/pop immediately; no partial update.
- Storage: circular array mem[0..DEPTH-1]. sp is the index of the next write and wraps DEPTH-1 -> 0 explicitly (no power-of-2 reliance).
- Top index: (sp==0 ? DEPTH-1 : sp-1).
- top_addr = mem[top index] when count>0, else 0. No registered output stage, so zero latency from state to output.
- All state updates occur on the rising clk edge. Priority is clear > push/pop.
- clear: count=0, sp=0, both flags=0. Entry contents are untouched. push/pop in the same cycle are ignored.
- push only, count<DEPTH: mem[sp]<=push_addr; sp advances; count+1.
- push only, count==DEPTH: handled per Optional Feature. overflow<=1 in both builds.
- pop only, count>0: sp retreats (0 -> DEPTH-1); count-1. The entry value is not erased.
- pop only, count==0: no state change except underflow<=1.
- push and pop, count>0: top entry is overwritten in place, i.e. mem[top index]<=push_addr. sp and count are unchanged; no overflow, even when full.
- push and pop, count==0: acts as push only (count becomes 1); underflow<=1.
- Flags: overflow and underflow stay set until clear or reset.
- Idle cycles (push=pop=clear=0): hold all state.
- Upstream suppresses push/pop on killed or stalled instructions; this block does not gate them.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined: a push when full overwrites the oldest entry. mem[sp]<=push_addr, sp advances, count stays DEPTH, and the oldest return address is lost. Deep recursion degrades gracefully.
- Undefined: a push when full is dropped. mem, sp and count are unchanged, and top_addr still shows the previous top.
- overflow is set identically in both builds.

Test Plan:
- Reset, then idle: count=0, empty=1, top_valid=0, top_addr=0, flags=0.
- Push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top_addr=0x030. Pop -> top_addr=0x020, count=2. Pop twice -> empty=1, underflow=0.
- DEPTH=8: push 0x100..0x107 -> full=1. Push 0x1FF:
  - RAS_WRAP_EN undefined: count=8, top_addr=0x107, overflow=1; eight pops return 0x107..0x100.
  - RAS_WRAP_EN defined: top_addr=0x1FF, overflow=1; eight pops return 0x1FF, 0x107..0x101.
- Push 0x040, then push 0x050 with pop in the same cycle -> count=1, top_addr=0x050. Then push+pop with 0x060 on an empty stack -> count=1, top_addr=0x060, underflow=1.
- Pop on empty -> underflow=1, count=0. Then push 0x070 -> underflow stays 1. clear -> count=0, underflow=0, overflow=0.
- Push 0x0AA, 0x0BB; drop rst_n low mid-cycle with push=1 -> outputs go to reset values asynchronously. After rst_n rises, top_valid=0 and count=0.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack for JSB/RET prediction in fetch/decode.
//
// Stores return PCs on push and presents the current top entry combinationally,
// so the fetch PC mux can use it in the same cycle that pop is asserted.
// Reports occupancy and sticky overflow/underflow flags for debug.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   push       store push_addr as the new top this cycle
//   pop        discard the top entry this cycle (push+pop replaces top in place)
//   push_addr  return address to store
//   clear      synchronous flush: empties the stack and clears the error flags
//   top_addr   current top entry (0 when empty)
//   top_valid  stack is non-empty
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: push seen while full
//   underflow  sticky: pop seen while empty
//
// Build option: define RAS_WRAP_EN to make a push while full overwrite the
// oldest entry; otherwise such a push is dropped.
module return_addr_stack #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          clear,
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] sp_inc;
  logic          is_full;
  logic          is_empty;

  // Explicit wrap so DEPTH need not be a power of two.
  assign top_idx  = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - PW'(1);
  assign sp_inc   = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + PW'(1);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;

    if (clear) begin
      // Entry contents are left alone; only bookkeeping is reset.
      sp_d        = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop) begin
      if (!is_empty) begin
        // Tail call style replace: overwrite top, occupancy unchanged.
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end else begin
        mem_we      = 1'b1;
        sp_d        = sp_inc;
        count_d     = CW'(1);
        underflow_d = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        mem_we  = 1'b1;
        sp_d    = sp_inc;
        count_d = count_q + CW'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef RAS_WRAP_EN
        // Slot at sp holds the oldest entry when full; overwrite it.
        mem_we = 1'b1;
        sp_d   = sp_inc;
`endif
      end
    end else if (pop) begin
      if (!is_empty) begin
        sp_d    = top_idx;
        count_d = count_q - CW'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= push_addr;
    end
  end

  assign top_addr  = is_empty ? '0 : mem_q[top_idx];
  assign top_valid = !is_empty;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack: a queue-based stack model predicts
// the post-edge observable state; a monitor compares one prediction per edge.
module tb_return_addr_stack;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, clear;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic          top_valid, full, empty, overflow, underflow;
  logic [CW-1:0] count;

  return_addr_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clear     (clear),
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [AW-1:0] top;
    logic          tv;
    logic          fl;
    logic          em;
    logic          ov;
    logic          un;
  } obs_t;

  // Reference model: the stack as a plain queue, newest at the back.
  logic [AW-1:0] stk[$];
  logic          m_ovf, m_unf;

  obs_t exp_q[$];
  int   tag_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_issue = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.cnt = CW'(stk.size());
    o.top = (stk.size() > 0) ? stk[stk.size() - 1] : '0;
    o.tv  = (stk.size() > 0);
    o.fl  = (stk.size() == DEPTH);
    o.em  = (stk.size() == 0);
    o.ov  = m_ovf;
    o.un  = m_unf;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.cnt = count;
    o.top = top_addr;
    o.tv  = top_valid;
    o.fl  = full;
    o.em  = empty;
    o.ov  = overflow;
    o.un  = underflow;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = dut_obs();
    n_total++;
    if (a === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got cnt=%0d top=%h tv=%b full=%b empty=%b ovf=%b unf=%b, expected cnt=%0d top=%h tv=%b full=%b empty=%b ovf=%b unf=%b",
               name, a.cnt, a.top, a.tv, a.fl, a.em, a.ov, a.un,
               e.cnt, e.top, e.tv, e.fl, e.em, e.ov, e.un);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle at the falling edge and queue the predicted post-edge state.
  task automatic do_cycle(input logic pu, input logic po, input logic cl,
                          input logic [AW-1:0] a);
    @(negedge clk);
    push = pu; pop = po; clear = cl; push_addr = a;
    if (cl) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pu && po) begin
      if (stk.size() > 0) stk[stk.size() - 1] = a;
      else begin
        stk.push_back(a);
        m_unf = 1'b1;
      end
    end else if (pu) begin
      if (stk.size() < DEPTH) stk.push_back(a);
      else begin
        m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(a);
`endif
      end
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_unf = 1'b1;
    end
    exp_q.push_back(model_obs());
    tag_q.push_back(n_issue++);
  endtask

  // Monitor: one comparison per rising edge while predictions are pending.
  initial begin
    obs_t e;
    int   t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("cycle%0d", t), e);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; push_addr = '0;
    model_reset();
    #12;
    check("in_reset", model_obs());
    @(negedge clk) rst_n = 1'b1;

    do_cycle(0, 0, 0, '0);                       // idle after reset
    do_cycle(1, 0, 0, 12'h010);
    do_cycle(1, 0, 0, 12'h020);
    do_cycle(1, 0, 0, 12'h030);
    do_cycle(0, 1, 0, '0);
    do_cycle(0, 1, 0, '0);
    do_cycle(0, 1, 0, '0);

    for (int i = 0; i < 8; i++) do_cycle(1, 0, 0, AW'(12'h100 + i));
    do_cycle(1, 0, 0, 12'h1FF);                  // push while full
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0, '0);
    do_cycle(0, 0, 1, '0);

    do_cycle(1, 0, 0, 12'h040);
    do_cycle(1, 1, 0, 12'h050);                  // replace top
    do_cycle(0, 1, 0, '0);
    do_cycle(1, 1, 0, 12'h060);                  // push+pop on empty
    do_cycle(0, 0, 1, '0);

    do_cycle(0, 1, 0, '0);                       // pop on empty
    do_cycle(1, 0, 0, 12'h070);
    do_cycle(0, 0, 1, '0);

    // Full + replace: push+pop while full must not set overflow.
    for (int i = 0; i < 8; i++) do_cycle(1, 0, 0, AW'(12'h200 + i));
    do_cycle(1, 1, 0, 12'h2EE);
    do_cycle(0, 0, 1, '0);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic pu, po;
      r  = $urandom_range(0, 99);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      do_cycle(pu, po, (r < 3), AW'($urandom));
    end

    // Asynchronous reset with a push in flight.
    do_cycle(0, 0, 1, '0);
    do_cycle(1, 0, 0, 12'h0AA);
    do_cycle(1, 0, 0, 12'h0BB);
    drain();
    @(negedge clk);
    push = 1'b1; push_addr = 12'h0CC;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", model_obs());
    @(posedge clk);
    #1 check("reset_hold", model_obs());
    @(negedge clk);
    push = 1'b0; rst_n = 1'b1;
    do_cycle(0, 0, 0, '0);
    do_cycle(1, 0, 0, 12'h0DD);

    drain();
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
      n_total += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
